// File: rtl/fdc_pkg.sv
// fdc_pkg: shared types for the IF/ID fetch/decode controller.
//   - instruction field positions (op[23:20] rd[19:16] rs1[15:12] rs2[11:8] imm8[7:0])
//   - opcode / ALU-op / FSM enums and the datapath control bundle
package fdc_pkg;

  localparam int INSTR_W = 24;
  localparam int IMM_W   = 8;
  localparam int CNT_W   = 16;

  localparam int OP_LSB  = 20;
  localparam int RD_LSB  = 16;
  localparam int RS1_LSB = 12;
  localparam int RS2_LSB = 8;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_ADD   = 4'h1,
    OP_SUB   = 4'h2,
    OP_AND   = 4'h3,
    OP_OR    = 4'h4,
    OP_ADDI  = 4'h5,
    OP_LD    = 4'h6,
    OP_ST    = 4'h7,
    OP_CMP   = 4'h8,
    OP_BEQ   = 4'h9,
    OP_BNE   = 4'hA,
    OP_JMP   = 4'hB,
    OP_SETLC = 4'hC,
    OP_LOOP  = 4'hD,
    OP_RSVD  = 4'hE,
    OP_HALT  = 4'hF
  } op_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_e;

  typedef struct packed {
    logic    reg_we;
    logic    mem_we;
    logic    mem_re;
    logic    alu_src_imm;
    alu_op_e alu_op;
    logic    illegal;
  } ctrl_t;

endpackage

// File: rtl/fdc_decoder.sv
// fdc_decoder: combinational opcode -> datapath control bundle.
//   op   : opcode held in the ID register
//   ctrl : reg/mem write enables, mem read, immediate operand select,
//          ALU op and reserved-opcode flag (not gated by validity here)
module fdc_decoder
  import fdc_pkg::*;
(
  input  op_e   op,
  output ctrl_t ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (op)
      OP_ADD:  ctrl.reg_we = 1'b1;
      OP_SUB:  begin ctrl.reg_we = 1'b1; ctrl.alu_op = ALU_SUB; end
      OP_AND:  begin ctrl.reg_we = 1'b1; ctrl.alu_op = ALU_AND; end
      OP_OR:   begin ctrl.reg_we = 1'b1; ctrl.alu_op = ALU_OR;  end
      OP_ADDI: begin ctrl.reg_we = 1'b1; ctrl.alu_src_imm = 1'b1; end
      OP_LD:   begin
        ctrl.reg_we      = 1'b1;
        ctrl.mem_re      = 1'b1;
        ctrl.alu_src_imm = 1'b1;
      end
      OP_ST:   begin ctrl.mem_we = 1'b1; ctrl.alu_src_imm = 1'b1; end
      OP_CMP:  ctrl.alu_op  = ALU_SUB;
      OP_RSVD: ctrl.illegal = 1'b1;
      default: ctrl = '0;  // NOP, branches, SETLC, LOOP, HALT
    endcase
  end

endmodule

// File: rtl/fetch_decode_ctrl.sv
// fetch_decode_ctrl: IF/ID stage.
//   CLK/reset           : clock, async active-low reset
//   instr               : instruction at PC (P+1 while P sits in ID)
//   zero_in/flag_we     : Z result and flag write from execute
//   PCSrc/immediate     : PC-relative redirect back to the PC block
//   id_valid, opcode, rd, rs1, rs2, imm_out, controls : decoded ID slot
//   halted/illegal/retired : status
module fetch_decode_ctrl
  import fdc_pkg::*;
#(
  parameter int INSTR_W = fdc_pkg::INSTR_W,
  parameter int IMM_W   = fdc_pkg::IMM_W,
  parameter int CNT_W   = fdc_pkg::CNT_W
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               zero_in,
  input  logic               flag_we,
  output logic               PCSrc,
  output logic [IMM_W-1:0]   immediate,
  output logic               id_valid,
  output logic [3:0]         opcode,
  output logic [3:0]         rd,
  output logic [3:0]         rs1,
  output logic [3:0]         rs2,
  output logic [IMM_W-1:0]   imm_out,
  output logic               reg_we,
  output logic               mem_we,
  output logic               mem_re,
  output logic               alu_src_imm,
  output logic [1:0]         alu_op,
  output logic               halted,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired
);

  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic               id_valid_q, id_valid_d;
  logic               z_q, z_d;
  logic [IMM_W-1:0]   lc_q, lc_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  state_e             state_q, state_d;

  op_e              op;
  logic [IMM_W-1:0] imm8;
  logic             z_eff;
  logic             taken;
  ctrl_t            ctrl;

  assign op   = op_e'(id_instr_q[OP_LSB +: 4]);
  assign imm8 = id_instr_q[IMM_W-1:0];

  fdc_decoder u_dec (.op(op), .ctrl(ctrl));

  always_comb begin
    // Bypass lets a CMP one slot ahead (now in EX) steer this branch.
    z_eff = flag_we ? zero_in : z_q;

    taken = 1'b0;
    if (id_valid_q) begin
      unique case (op)
        OP_JMP:  taken = 1'b1;
        OP_BEQ:  taken = z_eff;
        OP_BNE:  taken = !z_eff;
        OP_LOOP: taken = (lc_q > IMM_W'(1));
        default: taken = 1'b0;
      endcase
    end

    state_d    = state_q;
    id_instr_d = instr;
    id_valid_d = 1'b1;
    if (state_q == S_HALTED) begin
      id_instr_d = '0;
      id_valid_d = 1'b0;
    end else if (id_valid_q && op == OP_HALT) begin
      state_d    = S_HALTED;
      id_instr_d = '0;
      id_valid_d = 1'b0;
    end else if (taken) begin
      // P+1 is wrong-path once we redirect: squash it into a bubble.
      id_instr_d = '0;
      id_valid_d = 1'b0;
    end

    z_d = flag_we ? zero_in : z_q;

    lc_d = lc_q;
    if (id_valid_q && op == OP_SETLC) lc_d = imm8;
    else if (id_valid_q && op == OP_LOOP)
      lc_d = (lc_q > IMM_W'(1)) ? lc_q - IMM_W'(1) : '0;

    retired_d = retired_q;
    if (id_valid_q && retired_q != '1) retired_d = retired_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      id_instr_q <= '0;
      id_valid_q <= 1'b0;
      z_q        <= 1'b0;
      lc_q       <= '0;
      retired_q  <= '0;
      state_q    <= S_RUN;
    end else begin
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
      z_q        <= z_d;
      lc_q       <= lc_d;
      retired_q  <= retired_d;
      state_q    <= state_d;
    end
  end

  // PC block adds immediate to P+1, so pre-subtract one to land on P+imm8.
  assign PCSrc       = taken;
  assign immediate   = taken ? imm8 - IMM_W'(1) : '0;
  assign id_valid    = id_valid_q;
  assign opcode      = id_valid_q ? id_instr_q[OP_LSB  +: 4] : 4'h0;
  assign rd          = id_valid_q ? id_instr_q[RD_LSB  +: 4] : 4'h0;
  assign rs1         = id_valid_q ? id_instr_q[RS1_LSB +: 4] : 4'h0;
  assign rs2         = id_valid_q ? id_instr_q[RS2_LSB +: 4] : 4'h0;
  assign imm_out     = id_valid_q ? imm8 : '0;
  assign reg_we      = id_valid_q & ctrl.reg_we;
  assign mem_we      = id_valid_q & ctrl.mem_we;
  assign mem_re      = id_valid_q & ctrl.mem_re;
  assign alu_src_imm = id_valid_q & ctrl.alu_src_imm;
  assign alu_op      = id_valid_q ? ctrl.alu_op : 2'b00;
  assign illegal     = id_valid_q & ctrl.illegal;
  assign halted      = (state_q == S_HALTED);
  assign retired     = retired_q;

endmodule

// File: doc/fetch_decode_ctrl.md
Name: fetch_decode_ctrl

Overview:
- IF/ID stage directly downstream of the instruction-memory/PC block.
- Registers the 24-bit `instr` fetched each cycle and decodes it into fields and datapath controls.
- Resolves branches, JMP and hardware loops in ID. Drives `PCSrc` and `immediate` back to the PC block.
- Holds the flag register, the loop counter, the HALT state and a retired-instruction counter.

Parameters:
INSTR_W, 24, instruction width; format op[23:20] rd[19:16] rs1[15:12] rs2[11:8] imm8[7:0]
IMM_W, 8, immediate / branch-offset width
CNT_W, 16, retired counter width

Ports:
CLK  in  1  clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset)
instr  in  INSTR_W  fetched instruction from the PC/imem block, valid every cycle
zero_in  in  1  Z result from execute
flag_we  in  1  execute is writing flags this cycle (CMP/SUB in EX)
PCSrc  out  1  1 = PC <= PC + immediate at next edge
immediate  out  IMM_W  PC-relative redirect offset (two's complement)
id_valid  out  1  ID register holds a live instruction
opcode  out  4  decoded op
rd, rs1, rs2  out  4 each  register fields
imm_out  out  IMM_W  imm8 field
reg_we, mem_we, mem_re, alu_src_imm  out  1 each  datapath controls
alu_op  out  2  00 add, 01 sub, 10 and, 11 or
halted  out  1  core halted
illegal  out  1  reserved opcode in ID (one cycle per occurrence)
retired  out  CNT_W  count of valid instructions leaving ID

Behaviour:
- PC contract: each edge, PC <= PCSrc ? PC + immediate : PC + 1, and `instr` = imem[PC].
  - While instruction at address P sits in ID, `instr` shows P+1.
- Reset (async, reset=0), all state cleared:
  - id_valid=0, id_instr=0, PCSrc=0, immediate=0, all controls 0, flags Z=0, lc=0, halted=0, illegal=0, retired=0, state RUN.
  - First edge after release captures `instr`.
  - Reset mid-branch or mid-loop discards everything; no redirect survives.
- FSM states:
  - RUN: each edge, id_instr <= instr and id_valid <= 1, unless a redirect is issued this cycle. On redirect, id_valid <= 0 (wrong-path P+1 squashed; 1-bubble penalty).
  - HALTED: entered on the edge after a valid HALT in ID. id_valid=0, PCSrc=0, `instr` ignored. Exit only by reset.
- Opcodes (decode is combinational from the ID register; outputs 0 when id_valid=0):
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR: reg_we
  - 5 ADDI: reg_we, alu_src_imm
  - 6 LD: reg_we, mem_re, alu_src_imm
  - 7 ST: mem_we, alu_src_imm
  - 8 CMP: alu_op sub, no reg_we
  - 9 BEQ, A BNE, B JMP
  - C SETLC: lc <= imm8
  - D LOOP
  - F HALT
  - E reserved: illegal=1 for that cycle, otherwise NOP.
- Effective Z = flag_we ? zero_in : Z_reg. This bypass covers CMP immediately before the branch. Z_reg <= zero_in on every edge with flag_we=1.
- Taken conditions:
  - JMP: always.
  - BEQ: effective Z=1.
  - BNE: effective Z=0.
  - LOOP: lc > 1, then lc <= lc - 1. If lc <= 1, lc <= 0 and fall through.
- Taken redirect: PCSrc=1 and immediate = imm8 - 1 (mod 2^IMM_W) in the same cycle, so the target is P + imm8.
  - Example: imm8=0x00 gives immediate 0xFF (self-loop).
- Not taken: PCSrc=0, no bubble.
- retired: increments on each edge with id_valid=1, including branches and HALT. Saturates at all-ones.
- SETLC in ID while LOOP is in ID is impossible (single ID slot). SETLC write and LOOP decrement never coincide.

Decomposition:
- Package fdc_pkg: opcode enum (4-bit), alu_op enum, field bit positions, state enum {RUN, HALTED}.
- Sub-module fdc_decoder: purely combinational, maps op to the control bundle.
- Top module holds the ID register, flags, lc, FSM, redirect logic and counter.

Test Plan:
- Reset: hold reset=0 mid-run with lc=5 and Z=1 → all outputs 0, lc=0. First edge after release captures instr; id_valid=1 one cycle later.
- Stream: instr 0x131200 (ADD r3,r1,r2) → next cycle id_valid=1, opcode=1, rd=3, rs1=1, rs2=2, reg_we=1, PCSrc=0. ADDI 0x540007 → alu_src_imm=1, imm_out=0x07.
- JMP imm 0x05 in ID → PCSrc=1, immediate=0x04 same cycle; id_valid=0 next cycle. JMP imm 0x00 → immediate=0xFF.
- CMP then BEQ back-to-back:
  - flag_we=1, zero_in=1 in the BEQ cycle → taken via bypass.
  - zero_in=0 → PCSrc=0, no bubble.
  - BNE with Z_reg=0, flag_we=0 → taken.
- SETLC 3 then repeated LOOP imm 0xFE → taken twice (immediate=0xFD), falls through the third time, lc=0. SETLC 0 then LOOP → falls through.
- HALT in ID → halted=1 next cycle, PCSrc=0 and id_valid=0 thereafter regardless of instr, retired frozen. Opcode E → illegal=1 for one cycle, no controls asserted.
